// File: rtl/axis_traffic_endpoint.sv
// AXI-Stream traffic endpoint: sequence-numbered packet generator on the master
// stream plus a destination/length-checking sink with round-complete pulse.
module axis_traffic_endpoint #(
   parameter int          TDATAW       = 32,
   parameter int          TDESTW       = 4,
   parameter int          NUM_PACKETS  = 5,
   parameter int          PKT_LEN      = 4,
   parameter int          SRC_ID       = 0,
   parameter int          MY_ADDR      = 0,
   parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [TDESTW-1:0] DEST_BASE,
   input  logic [TDESTW-1:0] DEST_COUNT,
   input  logic [15:0]       EXPECT_RX,
   input  logic              RX_HOLD,
   output logic              BUSY,
   output logic              DONE,
   output logic [15:0]       RX_PKTS,
   output logic [15:0]       RX_ERRORS,
   output logic              AXIS_M_TVALID,
   input  logic              AXIS_M_TREADY,
   output logic [TDATAW-1:0] AXIS_M_TDATA,
   output logic              AXIS_M_TLAST,
   output logic [TDESTW-1:0] AXIS_M_TDEST,
   input  logic              AXIS_S_TVALID,
   output logic              AXIS_S_TREADY,
   input  logic [TDATAW-1:0] AXIS_S_TDATA,
   input  logic              AXIS_S_TLAST,
   input  logic [TDESTW-1:0] AXIS_S_TDEST
);
   localparam int BW = $clog2(PKT_LEN);
   localparam int PW = $clog2(NUM_PACKETS + 1);
   localparam logic [BW-1:0] LAST_BEAT   = BW'(PKT_LEN - 1);
   localparam logic [BW-1:0] PENULT_BEAT = BW'(PKT_LEN - 2);
   localparam logic [PW-1:0] LAST_PKT    = PW'(NUM_PACKETS - 1);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_HEADER  = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;

   logic [1:0]        state_reg;
   logic [BW-1:0]     beat_reg;
   logic [PW-1:0]     pkt_reg;
   logic [TDESTW-1:0] base_reg, count_reg, off_reg, off_inc;
   logic [15:0]       seq_reg, lfsr_reg, lfsr_next, lfsr_cur;
   logic              m_valid_reg, m_last_reg;
   logic [TDATAW-1:0] m_data_reg;
   logic [TDESTW-1:0] m_dest_reg;
   logic              m_accept, final_accept, start_run;

   function automatic logic [TDATAW-1:0] header_word(input logic [15:0] seq);
      logic [TDATAW-1:0] w;
      w = '0;
      w[TDATAW-1 -: 8] = 8'(SRC_ID);
      w[15:0] = seq;
      return w;
   endfunction

   assign lfsr_next    = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
   // Payload value of the beat following an accepted one: a header does not advance the LFSR.
   assign lfsr_cur     = (beat_reg == '0) ? lfsr_reg : lfsr_next;
   assign off_inc      = (off_reg == count_reg - 1'b1) ? '0 : off_reg + 1'b1;
   assign m_accept     = (state_reg != S_IDLE) && m_valid_reg && AXIS_M_TREADY;
   assign final_accept = m_accept && (beat_reg == LAST_BEAT) && (pkt_reg == LAST_PKT);
   assign start_run    = START && ((state_reg == S_IDLE) || final_accept);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg   <= S_IDLE;
         beat_reg    <= '0;
         pkt_reg     <= '0;
         base_reg    <= '0;
         count_reg   <= '0;
         off_reg     <= '0;
         seq_reg     <= '0;
         lfsr_reg    <= LFSR_DEFAULT;
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
         m_data_reg  <= '0;
         m_dest_reg  <= '0;
      end else begin
         if (m_accept) begin
            if (beat_reg == '0) seq_reg <= seq_reg + 16'd1;
            else                lfsr_reg <= lfsr_next;
         end
         if (start_run) begin
            state_reg   <= S_HEADER;
            pkt_reg     <= '0;
            beat_reg    <= '0;
            off_reg     <= '0;
            base_reg    <= DEST_BASE;
            count_reg   <= (DEST_COUNT == '0) ? TDESTW'(1) : DEST_COUNT;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
         end else if (state_reg != S_IDLE) begin
            if (!m_valid_reg) begin
               m_valid_reg <= 1'b1;
               m_data_reg  <= header_word(seq_reg);
               m_last_reg  <= 1'b0;
               m_dest_reg  <= base_reg + off_reg;
            end else if (AXIS_M_TREADY) begin
               if (beat_reg == LAST_BEAT) begin
                  if (pkt_reg == LAST_PKT) begin
                     state_reg   <= S_IDLE;
                     m_valid_reg <= 1'b0;
                     m_last_reg  <= 1'b0;
                  end else begin
                     state_reg  <= S_HEADER;
                     pkt_reg    <= pkt_reg + 1'b1;
                     beat_reg   <= '0;
                     off_reg    <= off_inc;
                     m_data_reg <= header_word(seq_reg);
                     m_last_reg <= 1'b0;
                     m_dest_reg <= base_reg + off_inc;
                  end
               end else begin
                  state_reg  <= S_PAYLOAD;
                  beat_reg   <= beat_reg + 1'b1;
                  m_data_reg <= {{(TDATAW-16){1'b0}}, lfsr_cur};
                  m_last_reg <= (beat_reg == PENULT_BEAT);
               end
            end
         end
      end
   end

   logic        s_ready_reg, bad_dest_reg, done_reg, s_accept, first_bad, pkt_bad;
   logic [15:0] rx_beat_reg, rx_pkts_reg, rx_err_reg, round_reg, rx_len, round_inc;

   assign s_accept  = AXIS_S_TVALID && s_ready_reg;
   assign first_bad = (rx_beat_reg == 16'd0) ? (AXIS_S_TDEST != TDESTW'(MY_ADDR)) : bad_dest_reg;
   assign rx_len    = (rx_beat_reg == 16'hFFFF) ? 16'hFFFF : rx_beat_reg + 16'd1;
   assign pkt_bad   = first_bad || (rx_len != 16'(PKT_LEN));
   assign round_inc = round_reg + 16'd1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s_ready_reg  <= 1'b0;
         bad_dest_reg <= 1'b0;
         done_reg     <= 1'b0;
         rx_beat_reg  <= '0;
         rx_pkts_reg  <= '0;
         rx_err_reg   <= '0;
         round_reg    <= '0;
      end else begin
         s_ready_reg <= ~RX_HOLD;
         done_reg    <= 1'b0;
         if (s_accept) begin
            if (AXIS_S_TLAST) begin
               rx_beat_reg  <= '0;
               bad_dest_reg <= 1'b0;
               rx_pkts_reg  <= rx_pkts_reg + 16'd1;
               if (pkt_bad && rx_err_reg != 16'hFFFF) rx_err_reg <= rx_err_reg + 16'd1;
               // A disabled round target keeps the counter parked at zero.
               if (EXPECT_RX == 16'd0) begin
                  round_reg <= '0;
               end else if (round_inc >= EXPECT_RX) begin
                  round_reg <= '0;
                  done_reg  <= 1'b1;
               end else begin
                  round_reg <= round_inc;
               end
            end else begin
               rx_beat_reg  <= rx_len;
               bad_dest_reg <= first_bad;
            end
         end
      end
   end

   assign BUSY          = (state_reg != S_IDLE);
   assign DONE          = done_reg;
   assign RX_PKTS       = rx_pkts_reg;
   assign RX_ERRORS     = rx_err_reg;
   assign AXIS_M_TVALID = m_valid_reg;
   assign AXIS_M_TDATA  = m_data_reg;
   assign AXIS_M_TLAST  = m_last_reg;
   assign AXIS_M_TDEST  = m_dest_reg;
   assign AXIS_S_TREADY = s_ready_reg;
endmodule

// File: tb/tb_axis_traffic_endpoint.sv
// Directed bench for axis_traffic_endpoint: table-driven TX runs and RX packets,
// plus hand sequences for mid-packet reset, RX hold and DONE rounds.
module tb_axis_traffic_endpoint;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        START = 1'b0;
   logic [3:0]  DEST_BASE = '0;
   logic [3:0]  DEST_COUNT = 4'd1;
   logic [15:0] EXPECT_RX = '0;
   logic        RX_HOLD = 1'b0;
   logic        BUSY, DONE;
   logic [15:0] RX_PKTS, RX_ERRORS;
   logic        AXIS_M_TVALID;
   logic        AXIS_M_TREADY = 1'b1;
   logic [31:0] AXIS_M_TDATA;
   logic        AXIS_M_TLAST;
   logic [3:0]  AXIS_M_TDEST;
   logic        AXIS_S_TVALID = 1'b0;
   logic        AXIS_S_TREADY;
   logic [31:0] AXIS_S_TDATA = '0;
   logic        AXIS_S_TLAST = 1'b0;
   logic [3:0]  AXIS_S_TDEST = '0;

   axis_traffic_endpoint #(.SRC_ID(3), .MY_ADDR(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START),
      .DEST_BASE(DEST_BASE), .DEST_COUNT(DEST_COUNT), .EXPECT_RX(EXPECT_RX),
      .RX_HOLD(RX_HOLD), .BUSY(BUSY), .DONE(DONE),
      .RX_PKTS(RX_PKTS), .RX_ERRORS(RX_ERRORS),
      .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
      .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TDEST(AXIS_M_TDEST),
      .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
      .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST), .AXIS_S_TDEST(AXIS_S_TDEST)
   );

   always #5 CLK = ~CLK;

   int done_cnt = 0;
   always @(negedge CLK) if (DONE) done_cnt++;

   typedef struct {
      logic [3:0]  base;
      logic [3:0]  count;
      bit          stall;
      logic [19:0] dests;   // packet p destination in bits [4p+3:4p]
   } tx_vec_t;

   typedef struct {
      logic [3:0]  dest;
      int          len;
      logic [15:0] pkts;
      logic [15:0] errs;
   } rx_vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_seq  = 16'd0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [31:0] cap [4];
   tx_vec_t     tx_tab [6];
   rx_vec_t     rx_tab [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   task automatic run_tx(input string tag, input tx_vec_t v);
      int k, cyc, stalls;
      logic [31:0] exp_data, obs;
      logic [3:0] exp_dest;
      logic valid_now;
      bit acc;
      DEST_BASE = v.base;
      DEST_COUNT = v.count;
      AXIS_M_TREADY = 1'b1;
      START = 1'b1;
      tick;
      START = 1'b0;
      check({tag, " busy_after_start"}, 32'(BUSY), 32'd1);
      check({tag, " tvalid_edge_n"}, 32'(AXIS_M_TVALID), 32'd0);
      tick;
      k = 0; cyc = 0; stalls = 0;
      while (k < 20 && cyc < 200) begin
         exp_data = (k % 4 == 0) ? {8'd3, 8'd0, m_seq} : {16'd0, m_lfsr};
         exp_dest = v.dests[4*(k/4) +: 4];
         valid_now = AXIS_M_TVALID;
         obs = AXIS_M_TDATA;
         check($sformatf("%s beat%0d tvalid", tag, k), 32'(AXIS_M_TVALID), 32'd1);
         check($sformatf("%s beat%0d tdata", tag, k), AXIS_M_TDATA, exp_data);
         check($sformatf("%s beat%0d tlast", tag, k), 32'(AXIS_M_TLAST), 32'(k % 4 == 3));
         check($sformatf("%s beat%0d tdest", tag, k), 32'(AXIS_M_TDEST), 32'(exp_dest));
         check($sformatf("%s beat%0d busy", tag, k), 32'(BUSY), 32'd1);
         acc = 1'b1;
         if (v.stall && k == 1 && stalls < 3) begin
            acc = 1'b0;
            stalls++;
         end
         AXIS_M_TREADY = acc;
         tick;
         cyc++;
         if (acc && valid_now) begin
            if (k % 4 == 0) m_seq = m_seq + 16'd1;
            else            m_lfsr = lfsr_step(m_lfsr);
            if (k < 4) cap[k] = obs;
            k++;
         end
      end
      AXIS_M_TREADY = 1'b1;
      check({tag, " beats_done"}, 32'(k), 32'd20);
      check({tag, " cycles"}, 32'(cyc), v.stall ? 32'd23 : 32'd20);
      check({tag, " busy_end"}, 32'(BUSY), 32'd0);
      check({tag, " tvalid_end"}, 32'(AXIS_M_TVALID), 32'd0);
   endtask

   task automatic send_rx(input logic [3:0] dest, input int len);
      int i, cyc;
      i = 0; cyc = 0;
      AXIS_S_TDEST = dest;
      while (i < len && cyc < 100) begin
         AXIS_S_TVALID = 1'b1;
         AXIS_S_TLAST = (i == len - 1);
         AXIS_S_TDATA = 32'(i);
         if (AXIS_S_TREADY) i++;
         tick;
         cyc++;
      end
      AXIS_S_TVALID = 1'b0;
      AXIS_S_TLAST = 1'b0;
      if (i < len) check("rx_send_timeout", 32'(i), 32'(len));
   endtask

   initial begin
      int cnt, cyc, d0;
      tx_tab[0] = '{4'd0,  4'd1, 1'b0, 20'h00000};
      tx_tab[1] = '{4'd0,  4'd1, 1'b0, 20'h00000};
      tx_tab[2] = '{4'd0,  4'd1, 1'b1, 20'h00000};
      tx_tab[3] = '{4'd2,  4'd3, 1'b0, 20'h32432};
      tx_tab[4] = '{4'd15, 4'd2, 1'b0, 20'hF0F0F};
      tx_tab[5] = '{4'd7,  4'd0, 1'b0, 20'h77777};
      rx_tab[0] = '{4'd1, 4, 16'd1, 16'd0};
      rx_tab[1] = '{4'd1, 3, 16'd2, 16'd1};
      rx_tab[2] = '{4'd2, 4, 16'd3, 16'd2};
      rx_tab[3] = '{4'd2, 3, 16'd4, 16'd3};
      rx_tab[4] = '{4'd1, 5, 16'd5, 16'd4};

      #2 RST_N = 1'b0;
      #1;
      check("rst tvalid", 32'(AXIS_M_TVALID), 32'd0);
      check("rst tdata", AXIS_M_TDATA, 32'd0);
      check("rst tlast", 32'(AXIS_M_TLAST), 32'd0);
      check("rst tdest", 32'(AXIS_M_TDEST), 32'd0);
      check("rst s_tready", 32'(AXIS_S_TREADY), 32'd0);
      check("rst busy", 32'(BUSY), 32'd0);
      check("rst done", 32'(DONE), 32'd0);
      check("rst rx_pkts", 32'(RX_PKTS), 32'd0);
      check("rst rx_errors", 32'(RX_ERRORS), 32'd0);
      tick;
      tick;
      RST_N = 1'b1;
      tick;
      check("s_tready after reset", 32'(AXIS_S_TREADY), 32'd1);

      run_tx("run0", tx_tab[0]);
      check("run0 hdr0", cap[0], 32'h03000000);
      check("run0 pay1", cap[1], 32'h0000ACE1);
      check("run0 pay2", cap[2], 32'h000059C3);
      check("run0 pay3", cap[3], 32'h0000B387);
      run_tx("run1", tx_tab[1]);
      check("run1 hdr seq5", cap[0], 32'h03000005);

      // Reset while packet 1 beat 2 is on the bus
      DEST_BASE = 4'd0; DEST_COUNT = 4'd1; AXIS_M_TREADY = 1'b1;
      START = 1'b1;
      tick;
      START = 1'b0;
      cnt = 0; cyc = 0;
      while (cnt < 6 && cyc < 100) begin
         if (AXIS_M_TVALID) cnt++;
         tick;
         cyc++;
      end
      check("midrst beats_before", 32'(cnt), 32'd6);
      check("midrst tvalid_before", 32'(AXIS_M_TVALID), 32'd1);
      #2 RST_N = 1'b0;
      #1;
      check("midrst tvalid", 32'(AXIS_M_TVALID), 32'd0);
      check("midrst busy", 32'(BUSY), 32'd0);
      check("midrst tdata", AXIS_M_TDATA, 32'd0);
      tick;
      tick;
      #2 RST_N = 1'b1;
      m_seq = 16'd0;
      m_lfsr = 16'hACE1;
      tick;

      run_tx("stall", tx_tab[2]);
      check("stall hdr0", cap[0], 32'h03000000);
      check("stall pay1", cap[1], 32'h0000ACE1);
      check("stall pay2", cap[2], 32'h000059C3);
      for (int i = 3; i < 6; i++) run_tx($sformatf("sweep%0d", i), tx_tab[i]);

      EXPECT_RX = 16'd0;
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) begin
         send_rx(rx_tab[i].dest, rx_tab[i].len);
         check($sformatf("rx%0d pkts", i), 32'(RX_PKTS), 32'(rx_tab[i].pkts));
         check($sformatf("rx%0d errs", i), 32'(RX_ERRORS), 32'(rx_tab[i].errs));
         check($sformatf("rx%0d done", i), 32'(DONE), 32'd0);
      end

      RX_HOLD = 1'b1;
      tick;
      check("hold s_tready", 32'(AXIS_S_TREADY), 32'd0);
      AXIS_S_TVALID = 1'b1; AXIS_S_TLAST = 1'b1; AXIS_S_TDEST = 4'd1;
      tick; tick; tick;
      check("hold rx_pkts", 32'(RX_PKTS), 32'd5);
      check("hold rx_errors", 32'(RX_ERRORS), 32'd4);
      AXIS_S_TVALID = 1'b0; AXIS_S_TLAST = 1'b0;
      RX_HOLD = 1'b0;
      tick;
      check("unhold s_tready", 32'(AXIS_S_TREADY), 32'd1);

      EXPECT_RX = 16'd5;
      for (int r = 1; r <= 10; r++) begin
         send_rx(4'd1, 4);
         check($sformatf("round pkt%0d done", r), 32'(DONE), (r % 5 == 0) ? 32'd1 : 32'd0);
         if (r % 5 == 0) begin
            tick;
            check($sformatf("round pkt%0d done_drop", r), 32'(DONE), 32'd0);
            check($sformatf("round pkt%0d pulses", r), 32'(done_cnt - d0), 32'(r / 5));
         end
      end
      EXPECT_RX = 16'd0;
      for (int r = 0; r < 5; r++) send_rx(4'd1, 4);
      tick;
      check("disabled pulses", 32'(done_cnt - d0), 32'd2);
      check("final rx_pkts", 32'(RX_PKTS), 32'd20);
      check("final rx_errors", 32'(RX_ERRORS), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
